// File: rtl/alu_z_stage.sv
// ALU stage driving the ZHigh:ZLow pair: single-cycle logic/add/shift ops plus
// iterative signed MUL (shift-add) and DIV (restoring) on operand magnitudes.
module alu_z_stage #(
  parameter int WIDTH  = 32,
  parameter int SAMT_W = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic [WIDTH-1:0] ZHigh,
  output logic [WIDTH-1:0] ZLow,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             illegal
);

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_NEG  = 4'h4, OP_NOT  = 4'h5, OP_SHR = 4'h6, OP_SHRA = 4'h7,
    OP_SHL  = 4'h8, OP_ROR  = 4'h9, OP_ROL = 4'hA, OP_MUL = 4'hB,
    OP_DIV  = 4'hC
  } op_e;

  // The start edge itself performs the operand load; RUN holds the WIDTH
  // iterations and FIX is the sign-correction/write-back cycle.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t            state, state_nxt;
  op_e               op_sel;
  logic              accept, is_multi;
  logic [SAMT_W-1:0] cnt;
  logic              is_div, neg_res, neg_rem, dz;
  logic [WIDTH-1:0]  a_raw, mag_b, hi, lo;
  logic [WIDTH-1:0]  sc_lo;
  logic              sc_ill;
  logic [SAMT_W-1:0] sh;
  logic [WIDTH-1:0]  hi_nxt, lo_nxt;
  logic [WIDTH:0]    mul_sum, div_shift;
  logic              div_ge;
  logic [2*WIDTH-1:0] mul_mag, mul_res;
  logic [WIDTH-1:0]  fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign op_sel   = op_e'(op);
  assign accept   = start && (state == S_IDLE);
  assign is_multi = (op_sel == OP_MUL) || (op_sel == OP_DIV);
  assign sh       = Rb[SAMT_W-1:0];
  assign busy     = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept && is_multi) state_nxt = S_RUN;
      S_RUN:   if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sc_lo  = '0;
    sc_ill = 1'b0;
    case (op_sel)
      OP_AND:  sc_lo = Ra & Rb;
      OP_OR:   sc_lo = Ra | Rb;
      OP_ADD:  sc_lo = Ra + Rb;
      OP_SUB:  sc_lo = Ra - Rb;
      OP_NEG:  sc_lo = -Rb;
      OP_NOT:  sc_lo = ~Rb;
      OP_SHR:  sc_lo = Ra >> sh;
      OP_SHRA: sc_lo = $unsigned($signed(Ra) >>> sh);
      OP_SHL:  sc_lo = Ra << sh;
      // A shift by WIDTH yields zero, so sh==0 returns Ra unchanged.
      OP_ROR:  sc_lo = (Ra >> sh) | (Ra << (WIDTH - int'(sh)));
      OP_ROL:  sc_lo = (Ra << sh) | (Ra >> (WIDTH - int'(sh)));
      OP_MUL, OP_DIV: sc_lo = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // One iteration: MUL adds the multiplicand when the multiplier LSB is set and
  // shifts right; DIV shifts the dividend into the remainder and trial-subtracts.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_b};
    if (is_div) begin
      hi_nxt = div_ge ? (div_shift[WIDTH-1:0] - mag_b) : div_shift[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    mul_mag = {hi, lo};
    mul_res = neg_res ? -mul_mag : mul_mag;
    if (!is_div) begin
      fix_hi = mul_res[2*WIDTH-1:WIDTH];
      fix_lo = mul_res[WIDTH-1:0];
    end else if (dz) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else begin
      fix_hi = neg_rem ? -hi : hi;
      fix_lo = neg_res ? -lo : lo;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ZHigh    <= '0;
      ZLow     <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      illegal  <= 1'b0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
      a_raw    <= '0;
      mag_b    <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            div_zero <= 1'b0;
            illegal  <= 1'b0;
            if (is_multi) begin
              a_raw   <= Ra;
              mag_b   <= mag(Rb);
              lo      <= mag(Ra);
              hi      <= '0;
              is_div  <= (op_sel == OP_DIV);
              neg_res <= Ra[WIDTH-1] ^ Rb[WIDTH-1];
              neg_rem <= Ra[WIDTH-1];
              dz      <= (op_sel == OP_DIV) && (Rb == '0);
              cnt     <= SAMT_W'(WIDTH - 1);
            end else begin
              ZHigh   <= '0;
              ZLow    <= sc_lo;
              illegal <= sc_ill;
              done    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          ZHigh    <= fix_hi;
          ZLow     <= fix_lo;
          div_zero <= dz;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_z_stage.sv
// Self-checking bench for alu_z_stage: an arithmetic/cycle-count reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_alu_z_stage;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op    = 4'h0;
  logic [31:0] Ra    = '0;
  logic [31:0] Rb    = '0;
  logic [31:0] ZHigh, ZLow;
  logic        busy, done, div_zero, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  alu_z_stage #(.WIDTH(32), .SAMT_W(5)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .Ra(Ra), .Rb(Rb),
    .ZHigh(ZHigh), .ZLow(ZLow), .busy(busy), .done(done),
    .div_zero(div_zero), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] zh;
    logic [31:0] zl;
    logic        ill;
    logic        dz;
  } res_t;

  // Reference result from plain signed arithmetic.
  function automatic res_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint sa, sb, p, q, m;
    int     s;
    logic [31:0] t;
    r = '0;
    s = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t = a;
    case (o)
      4'h0: r.zl = a & b;
      4'h1: r.zl = a | b;
      4'h2: r.zl = a + b;
      4'h3: r.zl = a - b;
      4'h4: r.zl = 32'd0 - b;
      4'h5: r.zl = ~b;
      4'h6: r.zl = a >> s;
      4'h7: r.zl = $unsigned($signed(a) >>> s);
      4'h8: r.zl = a << s;
      4'h9: begin
        for (int i = 0; i < s; i++) t = {t[0], t[31:1]};
        r.zl = t;
      end
      4'hA: begin
        for (int i = 0; i < s; i++) t = {t[30:0], t[31]};
        r.zl = t;
      end
      4'hB: begin
        p = sa * sb;
        r.zh = p[63:32];
        r.zl = p[31:0];
      end
      4'hC: begin
        if (b == 32'd0) begin
          r.zl = 32'hFFFFFFFF;
          r.zh = a;
          r.dz = 1'b1;
        end else begin
          q = sa / sb;
          m = sa % sb;
          r.zl = q[31:0];
          r.zh = m[31:0];
        end
      end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // Cycle-level expectation: multi-cycle ops finish on the 34th edge counting the start edge.
  res_t        mr;
  logic [31:0] e_zh = '0, e_zl = '0;
  logic        e_done = 1'b0, e_dz = 1'b0, e_ill = 1'b0;
  res_t        pend = '0;
  int          m_rem = 0;

  always_comb mr = model(op, Ra, Rb);

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      e_zh <= '0; e_zl <= '0; e_done <= 1'b0; e_dz <= 1'b0; e_ill <= 1'b0;
      m_rem <= 0;
    end else begin
      e_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          e_zh <= pend.zh; e_zl <= pend.zl; e_dz <= pend.dz; e_done <= 1'b1;
        end
      end else if (start) begin
        e_dz  <= 1'b0;
        e_ill <= 1'b0;
        if (op == 4'hB || op == 4'hC) begin
          pend  <= mr;
          m_rem <= 33;
        end else begin
          e_zh <= mr.zh; e_zl <= mr.zl; e_ill <= mr.ill; e_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    check("done", {63'd0, done}, {63'd0, e_done});
    check("busy", {63'd0, busy}, {63'd0, m_rem > 0});
    check("ZHigh", {32'd0, ZHigh}, {32'd0, e_zh});
    check("ZLow", {32'd0, ZLow}, {32'd0, e_zl});
    check("div_zero", {63'd0, div_zero}, {63'd0, e_dz});
    check("illegal", {63'd0, illegal}, {63'd0, e_ill});
  end

  task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] zh, input logic [31:0] zl,
                        input logic dz, input logic il, input int lat_exp, input bit pulse);
    int lat;
    @(negedge clock);
    start = 1'b1; op = o; Ra = a; Rb = b;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clock);
      if (lat == 1) begin
        start = 1'b0; op = 4'h2; Ra = 32'hDEAD0000; Rb = 32'h0000BEEF;
      end
      if (pulse && lat == 10) start = 1'b1;
      if (pulse && lat == 11) start = 1'b0;
      if (lat_exp > 1 && (lat == 1 || lat == lat_exp - 1))
        check({nm, "/busy_mid"}, {63'd0, busy}, 64'd1);
      if (done) break;
    end
    check({nm, "/latency"}, 64'(lat), 64'(lat_exp));
    check({nm, "/ZHigh"}, {32'd0, ZHigh}, {32'd0, zh});
    check({nm, "/ZLow"}, {32'd0, ZLow}, {32'd0, zl});
    check({nm, "/div_zero"}, {63'd0, div_zero}, {63'd0, dz});
    check({nm, "/illegal"}, {63'd0, illegal}, {63'd0, il});
    check({nm, "/busy_end"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    bit seen_done;
    repeat (2) @(negedge clock);
    check("reset/ZHigh", {32'd0, ZHigh}, 64'd0);
    check("reset/ZLow", {32'd0, ZLow}, 64'd0);
    check("reset/flags", {60'd0, busy, done, div_zero, illegal}, 64'd0);
    clear = 1'b0;

    // T1 / T2: single-cycle ops
    run_op("and0",  4'h0, 32'hAAAAAAAA, 32'h55555555, 32'h0, 32'h00000000, 0, 0, 1, 0);
    run_op("and1",  4'h0, 32'hFFFFFFFF, 32'hABCD1234, 32'h0, 32'hABCD1234, 0, 0, 1, 0);
    run_op("add",   4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h80000000, 0, 0, 1, 0);
    run_op("sub",   4'h3, 32'h00000000, 32'h00000001, 32'h0, 32'hFFFFFFFF, 0, 0, 1, 0);
    run_op("neg",   4'h4, 32'h12345678, 32'h00000005, 32'h0, 32'hFFFFFFFB, 0, 0, 1, 0);
    run_op("not",   4'h5, 32'h12345678, 32'h00000000, 32'h0, 32'hFFFFFFFF, 0, 0, 1, 0);
    run_op("shr",   4'h6, 32'h80000000, 32'h0000001F, 32'h0, 32'h00000001, 0, 0, 1, 0);
    run_op("shra",  4'h7, 32'h80000000, 32'h00000004, 32'h0, 32'hF8000000, 0, 0, 1, 0);
    run_op("shl0",  4'h8, 32'h12345678, 32'h00000020, 32'h0, 32'h12345678, 0, 0, 1, 0);
    run_op("ror",   4'h9, 32'h00000001, 32'h00000001, 32'h0, 32'h80000000, 0, 0, 1, 0);
    run_op("rol",   4'hA, 32'h80000001, 32'h00000001, 32'h0, 32'h00000003, 0, 0, 1, 0);
    run_op("rol0",  4'hA, 32'hC0FFEE11, 32'h00000000, 32'h0, 32'hC0FFEE11, 0, 0, 1, 0);

    // T3: MUL with an ignored mid-op start
    run_op("mul",   4'hB, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 34, 1);
    run_op("mulmin",4'hB, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0, 34, 0);

    // T4: DIV signs, divide by zero, overflow wrap
    run_op("div",   4'hC, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 34, 0);
    run_op("div2",  4'hC, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 0, 0, 34, 0);
    run_op("div3",  4'hC, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 0, 34, 0);
    run_op("divovf",4'hC, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, 34, 0);
    run_op("div0",  4'hC, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1, 0, 34, 0);
    run_op("dzclr", 4'h1, 32'h000000F0, 32'h0000000F, 32'h0, 32'h000000FF, 0, 0, 1, 0);

    // T5: asynchronous clear in the middle of a MUL
    @(negedge clock);
    start = 1'b1; op = 4'hB; Ra = 32'd5; Rb = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 clear = 1'b1;
    #1;
    check("clr/ZLow", {32'd0, ZLow}, 64'd0);
    check("clr/ZHigh", {32'd0, ZHigh}, 64'd0);
    check("clr/busy_done", {62'd0, busy, done}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) seen_done = 1'b1;
    end
    check("clr/no_done", {63'd0, seen_done}, 64'd0);
    run_op("addclr",4'h2, 32'h00000001, 32'h00000002, 32'h0, 32'h00000003, 0, 0, 1, 0);

    // T6: illegal op, then back-to-back single-cycle starts
    run_op("ill",   4'hE, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h00000000, 0, 1, 1, 0);
    @(negedge clock);
    start = 1'b1; op = 4'h2; Ra = 32'h00000001; Rb = 32'h00000002;
    @(negedge clock);
    check("b2b/done1", {63'd0, done}, 64'd1);
    check("b2b/ZLow1", {32'd0, ZLow}, 64'h3);
    check("b2b/ill_clr", {63'd0, illegal}, 64'd0);
    op = 4'h1; Ra = 32'h000000F0; Rb = 32'h0000000F;
    @(negedge clock);
    start = 1'b0;
    check("b2b/done2", {63'd0, done}, 64'd1);
    check("b2b/ZLow2", {32'd0, ZLow}, 64'hFF);
    @(negedge clock);
    check("b2b/done3", {63'd0, done}, 64'd0);
    check("b2b/hold", {32'd0, ZLow}, 64'hFF);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
